// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-input, W-bit registered multiplexer with round-robin
// arbitration and valid/ready handshaking on every port. It has one cycle
// of latency and full throughput. With PACKET=1, a grant is held from
// the first beat of a packet until the beat that carries last=1.
module rr_mux_arb #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int PACKET   = 0,
   localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS-1:0]       in_valid,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_last,
   output logic [CHANNELS-1:0]       in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_last,
   output logic [SELW-1:0]           out_sel,
   input  logic                      out_ready
);

   localparam logic [0:0]      ST_IDLE   = 1'b0;
   localparam logic [0:0]      ST_LOCKED = 1'b1;
   localparam logic [SELW-1:0] LAST_CH   = SELW'(CHANNELS - 1);

   logic [SELW-1:0]     ptr_r;
   logic [SELW-1:0]     lock_ch_r;
   logic [0:0]          state_r;
   logic                out_valid_r;
   logic [WIDTH-1:0]    out_data_r;
   logic                out_last_r;
   logic [SELW-1:0]     out_sel_r;

   logic [SELW-1:0]     rr_gnt_s;
   logic [SELW-1:0]     gnt_s;
   logic                load_s;
   logic                grant_s;
   logic                xfer_s;
   logic [CHANNELS-1:0] in_ready_s;
   logic [WIDTH-1:0]    sel_data_s;
   logic                sel_last_s;
   logic [SELW-1:0]     nxt_ptr_s;

   // Round-robin search: walk from ptr+CHANNELS-1 down to ptr so that the
   // last hit written is the first valid channel at or after ptr.
   always_comb begin
      int idx;
      rr_gnt_s = '0;
      for (int j = CHANNELS - 1; j >= 0; j--) begin
         idx = int'(ptr_r) + j;
         if (idx >= CHANNELS) begin
            idx = idx - CHANNELS;
         end else begin
            idx = idx;
         end
         if (in_valid[SELW'(idx)]) begin
            rr_gnt_s = SELW'(idx);
         end else begin
            rr_gnt_s = rr_gnt_s;
         end
      end
   end

   // Grant, handshake and the beat selected for the output register.
   // A locked packet keeps its channel even while that channel is idle.
   always_comb begin
      if ((PACKET != 0) && (state_r == ST_LOCKED)) begin
         gnt_s = lock_ch_r;
      end else begin
         gnt_s = rr_gnt_s;
      end
      load_s  = !out_valid_r || out_ready;
      grant_s = rst_n && load_s && (|in_valid);
      xfer_s  = grant_s && in_valid[gnt_s];
      in_ready_s = '0;
      sel_data_s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         in_ready_s[i] = grant_s && (gnt_s == SELW'(i));
         if (gnt_s == SELW'(i)) begin
            sel_data_s = in_data[i*WIDTH +: WIDTH];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
      if (PACKET != 0) begin
         sel_last_s = in_last[gnt_s];
      end else begin
         sel_last_s = 1'b1;
      end
      if (gnt_s == LAST_CH) begin
         nxt_ptr_s = '0;
      end else begin
         nxt_ptr_s = gnt_s + SELW'(1);
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_last  = out_last_r;
   assign out_sel   = out_sel_r;

   // Output register: load on an input transfer, else empty on a drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_last_r  <= 1'b0;
         out_sel_r   <= '0;
      end else if (xfer_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= sel_data_s;
         out_last_r  <= sel_last_s;
         out_sel_r   <= gnt_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Priority pointer: advance past the winner once its packet completes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_r <= '0;
      end else if (xfer_s && sel_last_s) begin
         ptr_r <= nxt_ptr_s;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Packet lock FSM: lock on a non-final first beat, unlock on last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         lock_ch_r <= '0;
      end else if ((PACKET != 0) && xfer_s) begin
         case (state_r)
            ST_IDLE: begin
               if (!sel_last_s) begin
                  state_r   <= ST_LOCKED;
                  lock_ch_r <= gnt_s;
               end else begin
                  state_r   <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (sel_last_s) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_LOCKED;
               end
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end else begin
         state_r   <= state_r;
         lock_ch_r <= lock_ch_r;
      end
   end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb: three instances cover per-beat arbitration
// (4 channels), packet mode (4 channels) and a non-power-of-two (3 channels).
// Inputs are driven on the falling edge; everything is observed #1 later.
module tb_rr_mux_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // u0: 4 channels, per-beat arbitration
   logic        rst0, ordy0, ov0, ol0;
   logic [3:0]  iv0, il0, ir0;
   logic [31:0] id0;
   logic [7:0]  od0;
   logic [1:0]  os0;
   // u1: 4 channels, packet mode
   logic        rst1, ordy1, ov1, ol1;
   logic [3:0]  iv1, il1, ir1;
   logic [31:0] id1;
   logic [7:0]  od1;
   logic [1:0]  os1;
   // u2: 3 channels, per-beat arbitration
   logic        rst2, ordy2, ov2, ol2;
   logic [2:0]  iv2, il2, ir2;
   logic [23:0] id2;
   logic [7:0]  od2;
   logic [1:0]  os2;

   rr_mux_arb #(.WIDTH(8), .CHANNELS(4), .PACKET(0)) u0 (
      .clk(clk), .rst_n(rst0), .in_valid(iv0), .in_data(id0), .in_last(il0),
      .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_last(ol0),
      .out_sel(os0), .out_ready(ordy0));

   rr_mux_arb #(.WIDTH(8), .CHANNELS(4), .PACKET(1)) u1 (
      .clk(clk), .rst_n(rst1), .in_valid(iv1), .in_data(id1), .in_last(il1),
      .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_last(ol1),
      .out_sel(os1), .out_ready(ordy1));

   rr_mux_arb #(.WIDTH(8), .CHANNELS(3), .PACKET(0)) u2 (
      .clk(clk), .rst_n(rst2), .in_valid(iv2), .in_data(id2), .in_last(il2),
      .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_last(ol2),
      .out_sel(os2), .out_ready(ordy2));

   initial begin
      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
      ordy0 = 1'b1; ordy1 = 1'b1; ordy2 = 1'b1;
      iv0 = 4'hF; il0 = 4'h0; iv1 = 4'h0; il1 = 4'h0; iv2 = 3'h0; il2 = 3'h0;
      id1 = 32'h0; id2 = 24'h0;
      for (int i = 0; i < 4; i++) id0[i*8 +: 8] = 8'hA0 + 8'(i);

      // ---------------- reset with all inputs valid ----------------
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", 32'(ir0), 32'h0);
      check("rst_out_valid", 32'(ov0), 32'h0);
      check("rst_out_sel", 32'(os0), 32'h0);
      check("rst_out_data", 32'(od0), 32'h0);

      // ---------------- fairness, per-beat mode ----------------
      @(negedge clk);
      rst0 = 1'b1;
      #1;
      check("fair_ready0", 32'(ir0), 32'h1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         check("fair_valid", 32'(ov0), 32'h1);
         check("fair_sel", 32'(os0), 32'(i % 4));
         check("fair_data", 32'(od0), 32'h0A0 + 32'(i % 4));
         check("fair_last", 32'(ol0), 32'h1);
         if (i < 7) check("fair_ready", 32'(ir0), 32'h1 << ((i + 1) % 4));
      end

      // ---------------- backpressure ----------------
      iv0 = 4'b0100;
      id0[23:16] = 8'h5C;
      #1;
      check("bp_ready_first", 32'(ir0), 32'h4);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         ordy0 = 1'b0;
         id0[23:16] = 8'h5D;
         #1;
         check("bp_hold_data", 32'(od0), 32'h5C);
         check("bp_hold_valid", 32'(ov0), 32'h1);
         check("bp_hold_sel", 32'(os0), 32'h2);
         check("bp_no_ready", 32'(ir0), 32'h0);
      end
      @(negedge clk);
      ordy0 = 1'b1;
      #1;
      check("bp_release_ready", 32'(ir0), 32'h4);
      @(negedge clk);
      iv0 = 4'h0;
      #1;
      check("bp_next_data", 32'(od0), 32'h5D);
      check("bp_next_valid", 32'(ov0), 32'h1);

      // ---------------- packet lock ----------------
      // ch0 single-beat packet first moves ptr to 1 so ch1 can win next.
      @(negedge clk);
      rst1 = 1'b1;
      iv1 = 4'b0011;
      id1[7:0] = 8'h10; il1[0] = 1'b1;
      id1[15:8] = 8'h21; il1[1] = 1'b0;
      #1;
      check("pk_ready_ch0", 32'(ir1), 32'h1);
      @(negedge clk);
      #1;
      check("pk_b0_sel", 32'(os1), 32'h0);
      check("pk_b0_data", 32'(od1), 32'h10);
      check("pk_b0_last", 32'(ol1), 32'h1);
      check("pk_ready_ch1", 32'(ir1), 32'h2);
      @(negedge clk);
      id1[15:8] = 8'h22;
      #1;
      check("pk_b1_sel", 32'(os1), 32'h1);
      check("pk_b1_data", 32'(od1), 32'h21);
      check("pk_b1_last", 32'(ol1), 32'h0);
      check("pk_locked", 32'(u1.state_r), 32'h1);
      check("pk_b2_ready", 32'(ir1), 32'h2);
      @(negedge clk);
      iv1 = 4'b0001;
      #1;
      check("pk_b2_sel", 32'(os1), 32'h1);
      check("pk_b2_data", 32'(od1), 32'h22);
      check("pk_bubble_ch0_blocked", 32'(ir1 & 4'b1101), 32'h0);
      @(negedge clk);
      iv1 = 4'b0011;
      id1[15:8] = 8'h23; il1[1] = 1'b1;
      #1;
      check("pk_bubble_valid", 32'(ov1), 32'h0);
      check("pk_b3_ready", 32'(ir1), 32'h2);
      @(negedge clk);
      iv1 = 4'b0001;
      #1;
      check("pk_b3_sel", 32'(os1), 32'h1);
      check("pk_b3_data", 32'(od1), 32'h23);
      check("pk_b3_last", 32'(ol1), 32'h1);
      check("pk_ptr_after", 32'(u1.ptr_r), 32'h2);
      check("pk_idle_after", 32'(u1.state_r), 32'h0);
      check("pk_ch0_ready", 32'(ir1), 32'h1);
      @(negedge clk);
      iv1 = 4'b1000;
      id1[31:24] = 8'h41; il1[3] = 1'b0;
      #1;
      check("pk_then_ch0_sel", 32'(os1), 32'h0);
      check("pk_then_ch0_data", 32'(od1), 32'h10);

      // ---------------- reset mid-packet ----------------
      check("mr_ch3_ready", 32'(ir1), 32'h8);
      @(negedge clk);
      check("mr_b1_sel", 32'(os1), 32'h3);
      check("mr_locked", 32'(u1.state_r), 32'h1);
      rst1 = 1'b0;
      iv1 = 4'b1001;
      #1;
      check("mr_rst_ready", 32'(ir1), 32'h0);
      check("mr_rst_valid", 32'(ov1), 32'h0);
      check("mr_rst_idle", 32'(u1.state_r), 32'h0);
      check("mr_rst_ptr", 32'(u1.ptr_r), 32'h0);
      @(negedge clk);
      rst1 = 1'b1;
      #1;
      check("mr_first_ready", 32'(ir1), 32'h1);
      @(negedge clk);
      iv1 = 4'h0;
      #1;
      check("mr_first_sel", 32'(os1), 32'h0);
      check("mr_first_data", 32'(od1), 32'h10);
      check("mr_idle", 32'(u1.state_r), 32'h0);

      // ---------------- sparse / wrap, 3 channels ----------------
      id2 = {8'h32, 8'h31, 8'h30};
      @(negedge clk);
      rst2 = 1'b1;
      iv2 = 3'b100;
      #1;
      check("wr_ready_ch2", 32'(ir2), 32'h4);
      @(negedge clk);
      iv2 = 3'b101;
      #1;
      check("wr_g0_sel", 32'(os2), 32'h2);
      check("wr_g0_data", 32'(od2), 32'h32);
      check("wr_ptr_wrap", 32'(u2.ptr_r), 32'h0);
      check("wr_ready_ch0", 32'(ir2), 32'h1);
      @(negedge clk);
      #1;
      check("wr_g1_sel", 32'(os2), 32'h0);
      check("wr_g1_data", 32'(od2), 32'h30);
      check("wr_ptr_1", 32'(u2.ptr_r), 32'h1);
      check("wr_ready_ch2b", 32'(ir2), 32'h4);
      @(negedge clk);
      iv2 = 3'b000;
      #1;
      check("wr_g2_sel", 32'(os2), 32'h2);
      check("wr_ptr_wrap2", 32'(u2.ptr_r), 32'h0);
      @(negedge clk);
      #1;
      check("wr_drained", 32'(ov2), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
